multdiv_ctrl: RTL
=================

MULTDIV_CTRL -- requirements
Module: multdiv_ctrl

Interface
REQ-001 SHALL have parameter DIV_CYCLES, default 32: number of div_enable cycles per division.
REQ-002 SHALL have parameter MULT_CYCLES, default 16: number of mult_enable cycles per multiplication.
REQ-003 SHALL have port clock  in  1: single clock; all state changes on rising edge.
REQ-004 SHALL have port reset  in  1: reset, synchronous and active-low.
REQ-005 SHALL have ports ctrl_MULT, ctrl_DIV  in  1 each: one-cycle operation start pulses.
REQ-006 SHALL have ports data_operandA, data_operandB  in  32 each: signed operands, sampled on the start edge.
REQ-007 SHALL have ports core_opA, core_opB  out  32 each: registered operands presented to the cores.
REQ-008 SHALL have ports core_start_mult, core_start_div  out  1 each: core load strobes.
REQ-009 SHALL have ports mult_enable, div_enable  out  1 each: core iteration enables.
REQ-010 SHALL have ports mult_result  in  32 and mult_overflow  in  1: signed multiplier outputs.
REQ-011 SHALL have port div_result  in  32: unsigned quotient from the divider core.
REQ-012 SHALL have ports data_result  out  32, data_exception  out  1, data_resultRDY  out  1, busy  out  1.

Function
REQ-013 SHALL implement states IDLE, LOAD_M, LOAD_D, RUN_M, RUN_D, FIN.
REQ-014 Start edge, ctrl_MULT: SHALL latch core_opA/core_opB = raw operands, then go to LOAD_M.
REQ-015 Start edge, ctrl_DIV: SHALL latch core_opA=|A| and core_opB=|B|, latch neg = A[31]^B[31], then go to LOAD_D.
  - |0x80000000| = 0x80000000, interpreted as unsigned.
REQ-016 Both ctrl_MULT and ctrl_DIV high on the same edge: ctrl_DIV SHALL win and ctrl_MULT SHALL be ignored.
REQ-017 LOAD_x: core_start_x SHALL be 1 for exactly that one cycle; next state RUN_x with counter=0.
REQ-018 RUN_x: x_enable SHALL be 1 in every cycle of RUN_x.
  - Counter increments each cycle; after the cycle with counter = N-1, transition to FIN.
  - N = MULT_CYCLES or DIV_CYCLES.
REQ-019 FIN, one cycle: SHALL register the final result at the FIN->IDLE edge.
  - data_result = mult_result, or div_result negated (two's complement) when neg=1.
  - data_exception = mult_overflow for MULT, 0 for DIV.
REQ-020 data_resultRDY SHALL be high for exactly one cycle: the first cycle after FIN.
  - Latency: start pulse sampled at end of cycle 0 -> RDY high in cycle N+3 (div: 35, mult: 19).
REQ-021 data_result and data_exception SHALL hold their values until the next result is written.
REQ-022 Divide by zero: on a ctrl_DIV start with data_operandB==0, SHALL go directly to FIN.
  - No core_start_div, no div_enable.
  - FIN writes data_result=0 and data_exception=1.
  - RDY high in cycle 2.
REQ-023 0x80000000 / 0xFFFFFFFF SHALL produce data_result=0x80000000 with data_exception=0 (wrap, no trap).
REQ-024 busy SHALL be 1 in every state except IDLE.
REQ-025 A start pulse in any non-IDLE state SHALL abort the current operation and restart per REQ-014..REQ-016.
  - The aborted operation SHALL never assert RDY.
  - data_result SHALL be unchanged by the abort.
REQ-026 Counter width SHALL be clog2(max(N))+1 bits; the counter SHALL never wrap within a run.
REQ-027 At most one of core_start_mult, core_start_div, mult_enable, div_enable SHALL be high in any cycle.

Reset
REQ-028 reset=0 at a rising edge SHALL force state IDLE and counter 0.
  - Outputs cleared: core_opA, core_opB, data_result, data_exception, data_resultRDY, busy, all strobes and enables.
REQ-029 Reset mid-operation SHALL discard the operation with no RDY; starts seen while reset=0 SHALL be ignored.
REQ-030 The first start accepted after reset release SHALL behave exactly as REQ-014..REQ-022.

Verification
REQ-031 DIV -7/2:
  - Required: core_opA=7, core_opB=2, div_enable high in cycles 2..33.
  - Model core returns 3 -> data_result=0xFFFFFFFD, exception 0, RDY only in cycle 35.
REQ-032 DIV 5/0:
  - Required: no core strobes, RDY in cycle 2, data_result=0, data_exception=1.
REQ-033 MULT 0x7FFFFFFF*2 with model core mult_result=0xFFFFFFFE, mult_overflow=1:
  - Required: mult_enable high in cycles 2..17, RDY in cycle 19, data_exception=1.
REQ-034 Simultaneous ctrl_MULT+ctrl_DIV, then ctrl_MULT in cycle 10 during RUN_D:
  - Required: division aborted, no RDY for it, mult result RDY in cycle 29, div_enable never high after cycle 10.
REQ-035 reset=0 in cycle 20 of a division:
  - Required: all outputs 0 in cycle 21, no RDY in any later cycle until a new start.
REQ-036 DIV 0x80000000/0xFFFFFFFF with model quotient 0x80000000:
  - Required: data_result=0x80000000, data_exception=0.

Source files
------------

// File: rtl/multdiv_ctrl.sv
// Sequencer for iterative multiply/divide cores: latches operands, strobes and
// enables the selected core, fixes up the quotient sign and publishes results.
module multdiv_ctrl #(
  parameter int DIV_CYCLES  = 32,
  parameter int MULT_CYCLES = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ctrl_MULT,
  input  logic        ctrl_DIV,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  output logic [31:0] core_opA,
  output logic [31:0] core_opB,
  output logic        core_start_mult,
  output logic        core_start_div,
  output logic        mult_enable,
  output logic        div_enable,
  input  logic [31:0] mult_result,
  input  logic        mult_overflow,
  input  logic [31:0] div_result,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY,
  output logic        busy
);

  localparam int MAX_CYCLES = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES) + 1;
  localparam logic [CW-1:0] MULT_LAST = CW'(MULT_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LAST  = CW'(DIV_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, LOAD_M, LOAD_D, RUN_M, RUN_D, FIN} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] count;
  logic          neg, op_div, div_zero, start;
  logic [31:0]   abs_a, abs_b;

  assign start = ctrl_MULT | ctrl_DIV;
  // Magnitudes for the unsigned divider; |0x80000000| stays 0x80000000.
  assign abs_a = data_operandA[31] ? 32'd0 - data_operandA : data_operandA;
  assign abs_b = data_operandB[31] ? 32'd0 - data_operandB : data_operandB;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_nxt       = state;
    core_start_mult = 1'b0;
    core_start_div  = 1'b0;
    mult_enable     = 1'b0;
    div_enable      = 1'b0;
    busy            = (state != IDLE);
    case (state)
      LOAD_M: begin
        core_start_mult = 1'b1;
        state_nxt       = RUN_M;
      end
      LOAD_D: begin
        core_start_div = 1'b1;
        state_nxt      = RUN_D;
      end
      RUN_M: begin
        mult_enable = 1'b1;
        if (count == MULT_LAST) state_nxt = FIN;
      end
      RUN_D: begin
        div_enable = 1'b1;
        if (count == DIV_LAST) state_nxt = FIN;
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // A start pulse restarts from any state; divide wins over multiply.
    if (ctrl_DIV)       state_nxt = (data_operandB == 32'd0) ? FIN : LOAD_D;
    else if (ctrl_MULT) state_nxt = LOAD_M;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      count          <= '0;
      neg            <= 1'b0;
      op_div         <= 1'b0;
      div_zero       <= 1'b0;
      core_opA       <= '0;
      core_opB       <= '0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      if (start) begin
        count  <= '0;
        op_div <= ctrl_DIV;
        if (ctrl_DIV) begin
          core_opA <= abs_a;
          core_opB <= abs_b;
          neg      <= data_operandA[31] ^ data_operandB[31];
          div_zero <= (data_operandB == 32'd0);
        end else begin
          core_opA <= data_operandA;
          core_opB <= data_operandB;
          neg      <= 1'b0;
          div_zero <= 1'b0;
        end
      end else begin
        case (state)
          RUN_M, RUN_D: count <= count + CW'(1);
          FIN: begin
            data_resultRDY <= 1'b1;
            if (div_zero) begin
              data_result    <= '0;
              data_exception <= 1'b1;
            end else if (op_div) begin
              data_result    <= neg ? 32'd0 - div_result : div_result;
              data_exception <= 1'b0;
            end else begin
              data_result    <= mult_result;
              data_exception <= mult_overflow;
            end
          end
          default: count <= '0;
        endcase
      end
    end
  end

endmodule
